reset_sequencer: RTL and testbench

//  Parametrised successor to the board-level clock/reset front end.
//  - Drives the reset of NUM_PLL clock managers and waits for all of them to lock, with timeout and bounded retry.
//  - Then releases NUM_OUT downstream resets in a fixed staggered order, one after another.
//  - Monitors lock continuously; any lock loss re-runs the whole sequence.
//  - Sits beside the clock wizards, clocked by the buffered input system clock.

---
 rtl/reset_seq_pkg.sv | 14 +
 rtl/sync_2ff.sv | 21 ++
 rtl/reset_sequencer.sv | 95 +++++++++
 tb/tb_reset_sequencer.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/reset_seq_pkg.sv
// reset_seq_pkg: state encoding, retry width and sizing helper shared by the reset sequencer
package reset_seq_pkg;
  localparam int RETRY_W = 4;
  typedef enum logic [2:0] {
    S_PLL_RST   = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_RELEASE   = 3'd2,
    S_RUN       = 3'd3,
    S_FAULT     = 3'd4
  } state_e;
  function automatic int max3(input int a, input int b, input int c);
    return (a > b) ? ((a > c) ? a : c) : ((b > c) ? b : c);
  endfunction
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: parametrised-width two-flop synchroniser for asynchronous level inputs
module sync_2ff #(
  parameter int W = 1
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);
  logic [W-1:0] meta_q, sync_q;
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end
  assign q_o = sync_q;
endmodule

// File: rtl/reset_sequencer.sv
// reset_sequencer: PLL reset/lock supervision with bounded retry and staggered downstream reset release
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int NUM_PLL          = 2,
  parameter int NUM_OUT          = 4,
  parameter int RST_HOLD_CYC     = 16,
  parameter int LOCK_TIMEOUT_CYC = 65536,
  parameter int STAGGER_CYC      = 8,
  parameter int MAX_RETRY        = 3
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               force_rst_i,
  input  logic [NUM_PLL-1:0] pll_locked_i,
  output logic [NUM_PLL-1:0] pll_rst_o,
  output logic [NUM_OUT-1:0] out_rst_o,
  output logic               all_ready_o,
  output logic               fault_o,
  output logic [RETRY_W-1:0] retry_cnt_o,
  output logic [2:0]         state_o
);
  // one shared counter; it never needs to reach the largest limit itself
  localparam int CNT_W = $clog2(max3(RST_HOLD_CYC, LOCK_TIMEOUT_CYC, STAGGER_CYC));
  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [RETRY_W-1:0] retry_q, retry_d;
  logic [NUM_OUT-1:0] out_rst_q, out_rst_d, out_shift;
  logic [NUM_PLL-1:0] locked_s;
  logic               pll_rst_q, pll_rst_d, all_ready_q, all_ready_d, fault_q, fault_d;
  logic               lock_all, hold_done, timeout, step;
  sync_2ff #(.W(NUM_PLL)) u_lock_sync (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .d_i   (pll_locked_i),
    .q_o   (locked_s)
  );
  assign lock_all  = &locked_s;
  assign hold_done = cnt_q == CNT_W'(RST_HOLD_CYC - 1);
  assign timeout   = cnt_q == CNT_W'(LOCK_TIMEOUT_CYC - 1);
  assign step      = cnt_q == CNT_W'(STAGGER_CYC - 1);
  assign out_shift = out_rst_q << 1;
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= S_PLL_RST;
      cnt_q       <= '0;
      retry_q     <= '0;
      out_rst_q   <= '1;
      pll_rst_q   <= 1'b1;
      all_ready_q <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      retry_q     <= retry_d;
      out_rst_q   <= out_rst_d;
      pll_rst_q   <= pll_rst_d;
      all_ready_q <= all_ready_d;
      fault_q     <= fault_d;
    end
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_PLL_RST:   state_d = hold_done ? S_WAIT_LOCK : S_PLL_RST;
      S_WAIT_LOCK: state_d = lock_all ? S_RELEASE :
                             !timeout ? S_WAIT_LOCK :
                             (retry_q < RETRY_W'(MAX_RETRY)) ? S_PLL_RST : S_FAULT;
      S_RELEASE:   state_d = !lock_all ? S_PLL_RST : (step && out_shift == '0) ? S_RUN : S_RELEASE;
      S_RUN:       state_d = lock_all ? S_RUN : S_PLL_RST;
      S_FAULT:     state_d = S_FAULT;
      default:     state_d = S_PLL_RST;
    endcase
    if (force_rst_i) state_d = S_PLL_RST;
  end
  // outputs are computed from the next state so they register in step with it
  always_comb begin
    cnt_d       = (force_rst_i || state_d != state_q || (state_q == S_RELEASE && step)) ? '0 :
                  (state_q == S_RUN || state_q == S_FAULT) ? cnt_q : cnt_q + CNT_W'(1);
    retry_d     = (force_rst_i || state_d == S_RUN) ? '0 :
                  (state_q == S_WAIT_LOCK && state_d == S_PLL_RST) ? retry_q + RETRY_W'(1) : retry_q;
    out_rst_d   = (state_d == S_RUN) ? '0 :
                  (state_d != S_RELEASE) ? '1 :
                  (state_q == S_RELEASE && step) ? out_shift : out_rst_q;
    pll_rst_d   = state_d == S_PLL_RST || state_d == S_FAULT;
    all_ready_d = state_d == S_RUN;
    fault_d     = state_d == S_FAULT;
  end
  assign pll_rst_o   = {NUM_PLL{pll_rst_q}};
  assign out_rst_o   = out_rst_q;
  assign all_ready_o = all_ready_q;
  assign fault_o     = fault_q;
  assign retry_cnt_o = retry_q;
  assign state_o     = state_q;
endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer: directed scenarios for lock wait, retry/fault, lock loss and staggered release
module tb_reset_sequencer;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       force_rst = 1'b0;
  logic [1:0] locks = 2'b00;
  logic [1:0] pll_rst;
  logic [3:0] out_rst;
  logic       all_ready, fault;
  logic [3:0] retry_cnt;
  logic [2:0] state;
  int         n_assert = 0;
  int         n_fail = 0;
  always #5 clk = ~clk;
  reset_sequencer #(
    .NUM_PLL(2), .NUM_OUT(4), .RST_HOLD_CYC(16),
    .LOCK_TIMEOUT_CYC(100), .STAGGER_CYC(8), .MAX_RETRY(2)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .force_rst_i (force_rst),
    .pll_locked_i(locks),
    .pll_rst_o   (pll_rst),
    .out_rst_o   (out_rst),
    .all_ready_o (all_ready),
    .fault_o     (fault),
    .retry_cnt_o (retry_cnt),
    .state_o     (state)
  );
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic wait_state(input logic [2:0] s, input int lim, output int n);
    int i;
    i = 0;
    n = -1;
    while (n < 0 && i < lim) begin
      tick();
      i++;
      if (state == s) n = i;
    end
  endtask
  task automatic test_reset();
    int n;
    logic [3:0] e;
    rst_n = 1'b0; locks = 2'b00; force_rst = 1'b0;
    repeat (5) tick();
    n_assert++; if (state !== 3'd0) begin n_fail++; $display("FAIL reset_state got=%0d want=0", state); end
    n_assert++; if (pll_rst !== 2'b11) begin n_fail++; $display("FAIL reset_pll_rst got=%b want=11", pll_rst); end
    n_assert++; if (out_rst !== 4'hF) begin n_fail++; $display("FAIL reset_out_rst got=%h want=f", out_rst); end
    n_assert++; if ({all_ready, fault, retry_cnt} !== 6'd0) begin n_fail++; $display("FAIL reset_flags got=%b want=000000", {all_ready, fault, retry_cnt}); end
    rst_n = 1'b1;
    wait_state(3'd1, 100, n);
    n_assert++; if (n !== 16) begin n_fail++; $display("FAIL hold_cycles got=%0d want=16", n); end
    n_assert++; if (pll_rst !== 2'b00) begin n_fail++; $display("FAIL wait_pll_rst got=%b want=00", pll_rst); end
    repeat (14) tick();
    locks = 2'b11;
    wait_state(3'd2, 20, n);
    n_assert++; if (n !== 3) begin n_fail++; $display("FAIL lock_latency got=%0d want=3", n); end
    for (int k = 1; k <= 32; k++) begin
      tick();
      e = 4'hF << (k / 8);
      n_assert++; if (out_rst !== e) begin n_fail++; $display("FAIL stagger_k%0d got=%h want=%h", k, out_rst, e); end
      n_assert++; if (all_ready !== (k >= 32)) begin n_fail++; $display("FAIL ready_k%0d got=%b want=%b", k, all_ready, k >= 32); end
    end
    n_assert++; if (state !== 3'd3) begin n_fail++; $display("FAIL run_state got=%0d want=3", state); end
  endtask
  task automatic test_retry_fault();
    int n;
    bit bad;
    locks = 2'b00;
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    for (int a = 0; a < 2; a++) begin
      wait_state(3'd1, 100, n);
      n_assert++; if (n !== 16) begin n_fail++; $display("FAIL retry%0d_hold got=%0d want=16", a, n); end
      n_assert++; if (retry_cnt !== 4'(a)) begin n_fail++; $display("FAIL retry%0d_cnt got=%0d want=%0d", a, retry_cnt, a); end
      wait_state(3'd0, 200, n);
      n_assert++; if (n !== 100) begin n_fail++; $display("FAIL retry%0d_timeout got=%0d want=100", a, n); end
      n_assert++; if (retry_cnt !== 4'(a + 1)) begin n_fail++; $display("FAIL retry%0d_inc got=%0d want=%0d", a, retry_cnt, a + 1); end
    end
    wait_state(3'd1, 100, n);
    wait_state(3'd4, 200, n);
    n_assert++; if (n !== 100) begin n_fail++; $display("FAIL fault_timeout got=%0d want=100", n); end
    n_assert++; if ({fault, pll_rst, out_rst, retry_cnt} !== {1'b1, 2'b11, 4'hF, 4'd2}) begin n_fail++; $display("FAIL fault_outs got=%b%b%h%0d want=111f2", fault, pll_rst, out_rst, retry_cnt); end
    bad = 1'b0;
    repeat (1000) begin
      tick();
      if (state !== 3'd4 || fault !== 1'b1 || pll_rst !== 2'b11 || out_rst !== 4'hF) bad = 1'b1;
    end
    n_assert++; if (bad) begin n_fail++; $display("FAIL fault_sticky state=%0d fault=%b want=4/1", state, fault); end
  endtask
  task automatic test_force_recover();
    int n;
    force_rst = 1'b1;
    tick();
    force_rst = 1'b0;
    locks = 2'b11;
    n_assert++; if ({state, fault, retry_cnt, pll_rst} !== {3'd0, 1'b0, 4'd0, 2'b11}) begin n_fail++; $display("FAIL force_clear got st=%0d f=%b r=%0d p=%b want 0/0/0/11", state, fault, retry_cnt, pll_rst); end
    wait_state(3'd1, 100, n);
    n_assert++; if (n !== 16) begin n_fail++; $display("FAIL force_hold got=%0d want=16", n); end
    wait_state(3'd2, 20, n);
    n_assert++; if (n !== 1) begin n_fail++; $display("FAIL force_lock got=%0d want=1", n); end
    wait_state(3'd3, 100, n);
    n_assert++; if (n !== 32) begin n_fail++; $display("FAIL force_release got=%0d want=32", n); end
    n_assert++; if ({all_ready, fault, retry_cnt, out_rst} !== {1'b1, 1'b0, 4'd0, 4'h0}) begin n_fail++; $display("FAIL force_run got rdy=%b f=%b r=%0d o=%h", all_ready, fault, retry_cnt, out_rst); end
  endtask
  task automatic test_lock_loss_run();
    int n;
    locks = 2'b01;
    tick();
    locks = 2'b11;
    wait_state(3'd0, 10, n);
    n_assert++; if (n !== 2) begin n_fail++; $display("FAIL loss_latency got=%0d want=2", n); end
    n_assert++; if ({out_rst, all_ready, retry_cnt} !== {4'hF, 1'b0, 4'd0}) begin n_fail++; $display("FAIL loss_outs got o=%h rdy=%b r=%0d want f/0/0", out_rst, all_ready, retry_cnt); end
    wait_state(3'd1, 100, n);
    n_assert++; if (n !== 16) begin n_fail++; $display("FAIL loss_hold got=%0d want=16", n); end
    wait_state(3'd3, 100, n);
    n_assert++; if (n !== 33) begin n_fail++; $display("FAIL loss_reseq got=%0d want=33", n); end
  endtask
  task automatic test_lock_loss_release();
    int n;
    force_rst = 1'b1;
    tick();
    force_rst = 1'b0;
    wait_state(3'd2, 100, n);
    n_assert++; if (n !== 17) begin n_fail++; $display("FAIL mid_entry got=%0d want=17", n); end
    repeat (16) tick();
    n_assert++; if (out_rst !== 4'hC) begin n_fail++; $display("FAIL mid_partial got=%h want=c", out_rst); end
    locks = 2'b10;
    repeat (2) tick();
    n_assert++; if (out_rst !== 4'hC) begin n_fail++; $display("FAIL mid_presync got=%h want=c", out_rst); end
    tick();
    n_assert++; if ({out_rst, state, all_ready} !== {4'hF, 3'd0, 1'b0}) begin n_fail++; $display("FAIL mid_reassert got o=%h st=%0d rdy=%b want f/0/0", out_rst, state, all_ready); end
    locks = 2'b11;
  endtask
  task automatic test_timeout_edge();
    int n;
    locks = 2'b00;
    force_rst = 1'b1;
    tick();
    force_rst = 1'b0;
    wait_state(3'd1, 100, n);
    wait_state(3'd0, 200, n);
    n_assert++; if (retry_cnt !== 4'd1) begin n_fail++; $display("FAIL edge_first_retry got=%0d want=1", retry_cnt); end
    wait_state(3'd1, 100, n);
    repeat (97) tick();
    locks = 2'b11;
    repeat (2) tick();
    n_assert++; if (state !== 3'd1) begin n_fail++; $display("FAIL edge_pre got=%0d want=1", state); end
    tick();
    n_assert++; if ({state, retry_cnt} !== {3'd2, 4'd1}) begin n_fail++; $display("FAIL edge_lock_wins got st=%0d r=%0d want 2/1", state, retry_cnt); end
    wait_state(3'd3, 100, n);
    n_assert++; if ({n, retry_cnt} !== {32'd32, 4'd0}) begin n_fail++; $display("FAIL edge_run got n=%0d r=%0d want 32/0", n, retry_cnt); end
  endtask
  task automatic test_force_hold();
    int n;
    bit bad;
    bad = 1'b0;
    force_rst = 1'b1;
    repeat (20) begin
      tick();
      if (state !== 3'd0 || pll_rst !== 2'b11 || out_rst !== 4'hF || all_ready !== 1'b0) bad = 1'b1;
    end
    force_rst = 1'b0;
    n_assert++; if (bad) begin n_fail++; $display("FAIL hold_force st=%0d p=%b want 0/11", state, pll_rst); end
    wait_state(3'd1, 100, n);
    n_assert++; if (n !== 16) begin n_fail++; $display("FAIL hold_release got=%0d want=16", n); end
  endtask
  initial begin
    test_reset();
    test_retry_fault();
    test_force_recover();
    test_lock_loss_run();
    test_lock_loss_release();
    test_timeout_edge();
    test_force_hold();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
